// File: rtl/shift_reg_ctrl_if.sv
// Control bundle between the sequencing controller and the 8-bit LED shift register.
// master = controller side, slave = shift register / key side.
interface shift_reg_ctrl_if;
  logic [3:0] key;
  logic [7:0] sr_q;
  logic       en;
  logic       dir;
  logic       load;
  logic [7:0] load_data;
  logic [3:0] cnt;
  logic [1:0] state;

  modport master (
    input  key, sr_q,
    output en, dir, load, load_data, cnt, state
  );

  modport slave (
    output key, sr_q,
    input  en, dir, load, load_data, cnt, state
  );
endinterface

// File: rtl/shift_reg_ctrl.sv
// Sequencing controller for the LED shift register: debounces four keys, issues
// shift/load strobes with ping-pong bounce at the register ends, and counts shifts.
module shift_reg_ctrl #(
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned DEB_CYCLES = 3,
  parameter logic [7:0]  SEED       = 8'h01
) (
  input  logic             clk,
  input  logic             rst,
  shift_reg_ctrl_if.master bus
);

  localparam int unsigned PreW = $clog2(CLK_DIV);
  localparam int unsigned DebW = $clog2(DEB_CYCLES + 1);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StLoad  = 2'd1,
    StRun   = 2'd2,
    StPause = 2'd3
  } state_e;

  logic [3:0]      r_sync1, r_sync2, r_db, r_db_q;
  logic [DebW-1:0] r_deb_cnt [4];

  state_e          r_state;
  logic [PreW-1:0] r_pre;
  logic            r_en, r_load, r_dir;
  logic [3:0]      r_cnt;

  logic [3:0] w_press;
  logic       w_reload, w_startstop, w_step_key, w_toggle;
  logic       w_tick, w_bounce, w_step;
  logic       w_unused_sr;

  // Key conditioning: 2-flop sync, then db follows after DEB_CYCLES consecutive mismatches.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_db    <= '0;
      r_db_q  <= '0;
      for (int i = 0; i < 4; i++) r_deb_cnt[i] <= '0;
    end else begin
      r_sync1 <= bus.key;
      r_sync2 <= r_sync1;
      r_db_q  <= r_db;
      for (int i = 0; i < 4; i++) begin
        if (r_sync2[i] != r_db[i]) begin
          if (r_deb_cnt[i] == DebW'(DEB_CYCLES - 1)) begin
            r_db[i]      <= r_sync2[i];
            r_deb_cnt[i] <= '0;
          end else begin
            r_deb_cnt[i] <= r_deb_cnt[i] + 1'b1;
          end
        end else begin
          r_deb_cnt[i] <= '0;
        end
      end
    end
  end

  assign w_press = r_db & ~r_db_q;

  // Only the highest-priority key that means something in the current state acts.
  always_comb begin
    w_reload    = 1'b0;
    w_startstop = 1'b0;
    w_step_key  = 1'b0;
    w_toggle    = 1'b0;
    case (r_state)
      StIdle:  w_startstop = w_press[0];
      StRun: begin
        if (w_press[3])      w_reload    = 1'b1;
        else if (w_press[0]) w_startstop = 1'b1;
        else if (w_press[2]) w_toggle    = 1'b1;
      end
      StPause: begin
        if (w_press[3])      w_reload    = 1'b1;
        else if (w_press[0]) w_startstop = 1'b1;
        else if (w_press[1]) w_step_key  = 1'b1;
        else if (w_press[2]) w_toggle    = 1'b1;
      end
      default: ;
    endcase
  end

  assign w_tick   = (r_state == StRun) && (r_pre == PreW'(CLK_DIV - 1));
  assign w_bounce = r_dir ? bus.sr_q[0] : bus.sr_q[7];
  assign w_step   = w_step_key | (w_tick & ~(w_reload | w_startstop | w_toggle));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= StIdle;
      r_pre   <= '0;
      r_en    <= 1'b0;
      r_load  <= 1'b0;
      r_dir   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_en   <= 1'b0;
      r_load <= 1'b0;
      if (r_state == StRun) r_pre <= w_tick ? '0 : r_pre + 1'b1;
      if (w_step) begin
        if (w_bounce) begin
          r_dir <= ~r_dir;
        end else begin
          r_en  <= 1'b1;
          r_cnt <= r_cnt + 4'd1;
        end
      end
      if (w_toggle) r_dir <= ~r_dir;
      case (r_state)
        StIdle: begin
          if (w_startstop) begin
            r_state <= StLoad;
            r_load  <= 1'b1;
            r_dir   <= 1'b0;
            r_cnt   <= '0;
          end
        end
        StLoad: begin
          r_state <= StRun;
          r_pre   <= '0;
        end
        StRun: begin
          if (w_reload) begin
            r_state <= StLoad;
            r_load  <= 1'b1;
            r_dir   <= 1'b0;
            r_cnt   <= '0;
          end else if (w_startstop) begin
            r_state <= StPause;
          end
        end
        StPause: begin
          if (w_reload) begin
            r_state <= StLoad;
            r_load  <= 1'b1;
            r_dir   <= 1'b0;
            r_cnt   <= '0;
          end else if (w_startstop) begin
            r_state <= StRun;
            r_pre   <= '0;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.en        = r_en;
  assign bus.dir       = r_dir;
  assign bus.load      = r_load;
  assign bus.load_data = SEED;
  assign bus.cnt       = r_cnt;
  assign bus.state     = r_state;

  // Only the end bits matter for the bounce decision.
  assign w_unused_sr = ^bus.sr_q[6:1];

endmodule

// File: tb/tb_shift_reg_ctrl.sv
// Bench for shift_reg_ctrl: plant shift register on sr_q, an event-level reference
// model compared every cycle, and directed scenarios with literal expectations.
module tb_shift_reg_ctrl;

  localparam int unsigned ClkDiv = 4;
  localparam int unsigned Deb    = 3;
  localparam logic [7:0]  Seed   = 8'h01;

  logic clk = 1'b0;
  logic rst = 1'b0;

  shift_reg_ctrl_if bus ();

  shift_reg_ctrl #(
    .CLK_DIV   (ClkDiv),
    .DEB_CYCLES(Deb),
    .SEED      (Seed)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial forever #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
  endtask

  // Plant: the shift register the controller drives.
  always @(posedge clk or negedge rst) begin
    if (!rst)          bus.sr_q <= 8'h00;
    else if (bus.load) bus.sr_q <= bus.load_data;
    else if (bus.en)   bus.sr_q <= bus.dir ? (bus.sr_q >> 1) : (bus.sr_q << 1);
  end

  // Reference model: debounce as a window over raw key samples, ticks as absolute edge numbers.
  int          m_edge = 0;
  logic [15:0] m_win [4];
  logic [3:0]  m_db, m_pend;
  int          m_state, m_cnt, m_next_tick;
  logic        m_dir, m_en, m_load;
  logic [7:0]  m_sr;

  task automatic model_reset();
    for (int k = 0; k < 4; k++) m_win[k] = '0;
    m_db = '0; m_pend = '0;
    m_state = 0; m_cnt = 0; m_next_tick = 0;
    m_dir = 0; m_en = 0; m_load = 0; m_sr = 8'h00;
  endtask

  task automatic enter_load();
    m_state = 1; m_load = 1; m_dir = 0; m_cnt = 0;
  endtask

  task automatic do_step();
    if ((!m_dir && m_sr[7]) || (m_dir && m_sr[0])) m_dir = !m_dir;
    else begin m_en = 1; m_cnt = (m_cnt + 1) % 16; end
  endtask

  task automatic model_step();
    logic [7:0] sr_next;
    logic [3:0] p;
    bit         tick, flip;
    m_edge++;
    sr_next = m_sr;
    if (m_load)    sr_next = Seed;
    else if (m_en) sr_next = m_dir ? (m_sr >> 1) : (m_sr << 1);
    p = m_pend;
    m_en = 0; m_load = 0;
    case (m_state)
      0: if (p[0]) enter_load();
      1: begin m_state = 2; m_next_tick = m_edge + ClkDiv; end
      2: begin
        tick = (m_edge == m_next_tick);
        if (tick) m_next_tick += ClkDiv;
        if (p[3])      enter_load();
        else if (p[0]) m_state = 3;
        else if (p[2]) m_dir = !m_dir;
        else if (tick) do_step();
      end
      default: begin
        if (p[3])      enter_load();
        else if (p[0]) begin m_state = 2; m_next_tick = m_edge + ClkDiv; end
        else if (p[1]) do_step();
        else if (p[2]) m_dir = !m_dir;
      end
    endcase
    m_sr = sr_next;
    m_pend = '0;
    for (int k = 0; k < 4; k++) begin
      flip = 1;
      for (int j = 1; j <= Deb; j++) if (m_win[k][j] == m_db[k]) flip = 0;
      if (flip) begin
        m_db[k] = !m_db[k];
        if (m_db[k]) m_pend[k] = 1;
      end
      m_win[k] = {m_win[k][14:0], bus.key[k]};
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        if (clk) m_edge++;
        model_reset();
      end else begin
        model_step();
      end
    end
  end

  // Every-cycle comparison against the model.
  initial forever begin
    @(negedge clk);
    check("cmp_en",        bus.en,        m_en);
    check("cmp_load",      bus.load,      m_load);
    check("cmp_dir",       bus.dir,       m_dir);
    check("cmp_cnt",       bus.cnt,       m_cnt);
    check("cmp_state",     bus.state,     m_state);
    check("cmp_load_data", bus.load_data, Seed);
  end

  // Event recorder, sampled just after each edge.
  int en_total = 0, last_en_edge = -1, last_load_edge = -1, last_run_edge = -1;
  int ld_cnt = -1, ld_dir = -1, ld_state = -1, prev_state = 0;

  initial forever begin
    @(posedge clk);
    #1;
    if (bus.load) begin
      last_load_edge = m_edge; ld_cnt = bus.cnt; ld_dir = bus.dir; ld_state = bus.state;
    end
    if (bus.en) begin en_total++; last_en_edge = m_edge; end
    if (bus.state == 2 && prev_state != 2) last_run_edge = m_edge;
    prev_state = bus.state;
  end

  task automatic wait_en(input string name, input int budget, output int edge_o);
    int start;
    start  = en_total;
    edge_o = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (en_total != start) begin
        edge_o = last_en_edge;
        return;
      end
    end
    check({name, "_timeout"}, 0, 1);
  endtask

  task automatic hold_key(input logic [3:0] mask, input int cycles);
    bus.key = mask;
    repeat (cycles) @(negedge clk);
    bus.key = 4'h0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, e_prev, e_cur, n0;
    bus.key = 4'h0;
    rst     = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_state", bus.state, 0);
    check("rst_cnt", bus.cnt, 0);
    rst = 1'b1;
    repeat (50) @(negedge clk);
    check("idle_state", bus.state, 0);
    check("idle_load_count", last_load_edge, -1);

    // Start from IDLE: load after edge 6 counted from first sampling edge.
    t0 = m_edge + 1;
    hold_key(4'b0001, 8);
    check("start_load_edge", last_load_edge - t0 + 1, 6);
    check("start_load_state", ld_state, 1);
    check("start_state_run", bus.state, 2);
    check("load_data", bus.load_data, 8'h01);
    wait_en("en1", 10, e_cur);
    check("first_en_gap", e_cur - last_run_edge, 4);
    check("cnt_1", bus.cnt, 1);
    e_prev = e_cur;
    wait_en("en2", 10, e_cur);
    check("en2_gap", e_cur - e_prev, 4);
    check("cnt_2", bus.cnt, 2);
    e_prev = e_cur;
    wait_en("en3", 10, e_cur);
    check("cnt_3", bus.cnt, 3);
    e_prev = e_cur;

    // Glitch: 2-sample key0 pulse must not pause.
    hold_key(4'b0001, 2);
    wait_en("en4", 10, e_cur);
    check("glitch_gap", e_cur - e_prev, 4);
    check("glitch_state", bus.state, 2);
    check("cnt_4", bus.cnt, 4);
    for (int i = 5; i <= 7; i++) begin
      wait_en("en_run", 10, e_cur);
      check("cnt_run", bus.cnt, i);
    end
    e_prev = e_cur;

    // Bounce at MSB.
    repeat (4) @(negedge clk);
    check("bounce_sr", bus.sr_q, 8'h80);
    check("bounce_dir", bus.dir, 1);
    check("bounce_en", bus.en, 0);
    check("bounce_cnt", bus.cnt, 7);
    wait_en("en8", 10, e_cur);
    check("bounce_gap", e_cur - e_prev, 8);
    check("after_bounce_dir", bus.dir, 1);
    check("cnt_8", bus.cnt, 8);

    // Pause, step, resume.
    hold_key(4'b0001, 8);
    check("pause_state", bus.state, 3);
    check("pause_cnt", bus.cnt, 9);
    n0 = en_total;
    repeat (20) @(negedge clk);
    check("pause_no_en", en_total - n0, 0);
    n0 = en_total;
    hold_key(4'b0010, 8);
    repeat (12) @(negedge clk);
    check("step_one_en", en_total - n0, 1);
    check("step_cnt", bus.cnt, 10);
    check("step_state", bus.state, 3);
    hold_key(4'b0001, 8);
    wait_en("resume_en", 10, e_cur);
    check("resume_gap", e_cur - last_run_edge, 4);
    check("resume_cnt", bus.cnt, 11);

    // key3+key0 together: reload wins.
    last_load_edge = -1;
    t0 = m_edge + 1;
    hold_key(4'b1001, 8);
    check("reload_edge", last_load_edge - t0 + 1, 6);
    check("reload_state", ld_state, 1);
    check("reload_cnt", ld_cnt, 0);
    check("reload_dir", ld_dir, 0);
    check("reload_after_state", bus.state, 2);
    wait_en("rl_en1", 12, e_cur);
    wait_en("rl_en2", 12, e_cur);
    check("rl_cnt", bus.cnt, 2);

    // Asynchronous reset mid-RUN.
    #2 rst = 1'b0;
    #1;
    check("arst_en", bus.en, 0);
    check("arst_load", bus.load, 0);
    check("arst_dir", bus.dir, 0);
    check("arst_cnt", bus.cnt, 0);
    check("arst_state", bus.state, 0);
    check("arst_load_data", bus.load_data, 8'h01);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    check("post_rst_state", bus.state, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/shift_reg_ctrl.md
# shift_reg_ctrl

- Sequencing controller for the 8-bit LED shift register datapath.
- Debounces the four board keys and turns them into start/pause, single-step, direction and reload commands.
- Produces the registered `en`, `dir`, `load` and `load_data` controls that drive the shift register. Applies ping-pong bounce at the register ends, using the register's current contents fed back on `sr_q`.
- Counts issued shifts for the display.

## Interface
Parameters:
- `CLK_DIV`, 4: clocks between shift ticks in RUN (≥2).
- `DEB_CYCLES`, 3: consecutive stable synchronized samples required to accept a key change (≥1).
- `SEED`, 8'h01: value driven on `load_data`.

Ports:
- `clk`  in  1  single clock.
- `rst`  in  1  asynchronous, active-low reset.
- `key`  in  4  raw active-high buttons (asynchronous). key[0] start/pause, key[1] step, key[2] direction toggle, key[3] reload.
- `sr_q`  in  8  current shift register contents.
- `en`  out  1  one-cycle shift strobe.
- `dir`  out  1  0 = shift toward MSB, 1 = shift toward LSB.
- `load`  out  1  one-cycle parallel-load strobe.
- `load_data`  out  8  load value, constant `SEED`.
- `cnt`  out  4  shifts issued since last load, mod 16.
- `state`  out  2  IDLE=0, LOAD=1, RUN=2, PAUSE=3.

## Operation
**Key conditioning (per key)**
- Two-flop synchronizer, then a debounced level `db`.
- When the synchronized value differs from `db` for `DEB_CYCLES` consecutive edges, `db` takes the new value. Any mismatch gap clears the counter.
- A press is a `db` rising edge. It is a one-cycle internal pulse; releases produce no action.

**Command priority and tick suppression**
- At most one command acts per cycle, priority key3 > key0 > key1 > key2. Lower simultaneous presses are discarded.
- Any accepted command suppresses a coincident prescaler tick (no `en` that cycle).

**FSM**
- IDLE: no strobes. key0 → LOAD. All other keys ignored.
- LOAD: one cycle with `load`=1. Clears `dir` and `cnt`, then goes to RUN.
- RUN:
  - Prescaler counts 0..`CLK_DIV`-1; the tick occurs at `CLK_DIV`-1, then it wraps.
  - key0 → PAUSE. key3 → LOAD. key2 toggles `dir`. key1 ignored.
- PAUSE:
  - Prescaler frozen.
  - key0 → RUN, with the prescaler cleared to 0.
  - key1 performs one step (same rule as a tick). key2 toggles `dir`. key3 → LOAD.

**Step rule (tick or key1 step)**
- If `dir`=0 and `sr_q[7]`=1, or `dir`=1 and `sr_q[0]`=1: toggle `dir`, no `en`, `cnt` unchanged (bounce).
- Otherwise: `en`=1 for one cycle and `cnt` += 1, wrapping 15→0.
- `sr_q` = 0 never bounces.

**Outputs**
- All outputs are registered. `dir` is stable in the cycle `en` is high.

## Timing
**Reset (`rst`=0)**
- Acts immediately, including mid-RUN or mid-LOAD.
- State IDLE, `en`=0, `load`=0, `dir`=0, `cnt`=0, `state`=0.
- `load_data`=`SEED` at all times.
- Synchronizers, `db`, debounce counters and prescaler all cleared.

**Press latency**
- Count edge 1 as the first edge sampling the key high, held stable.
- `db` rises at edge `DEB_CYCLES`+2.
- The resulting output change (state, `load`, `dir` or `en`) is visible after edge `DEB_CYCLES`+3. With defaults that is edge 6.

**LOAD timing**
- `load` is high exactly one cycle.
- `state`=1 during that cycle and 2 after it.

**RUN timing**
- First `en` comes `CLK_DIV` cycles after `state` becomes 2. Subsequent `en` pulses follow every `CLK_DIV` cycles.
- A bounce consumes one tick slot, so there is a 2×`CLK_DIV` gap between the `en` pulses around the bounce.

**Glitch rejection**
- A key held for fewer than `DEB_CYCLES` synchronized samples produces no action.

## Test plan
Defaults throughout (`CLK_DIV`=4, `DEB_CYCLES`=3, `SEED`=8'h01). The bench models the shift register driving `sr_q`.

1. **Reset:** `rst`=0 for 5 cycles, then release with keys idle for 50 cycles → `en`=`load`=`dir`=0, `cnt`=0, `state`=0 throughout.
2. **Start:** key0 high 8 cycles from IDLE → `load`=1 exactly one cycle after edge 6 with `load_data`=8'h01, `state` then 2. `en` pulses every 4 cycles; `cnt` reads 1, 2, 3, …
3. **Glitch:** key0 high 2 cycles in RUN → no state change, `en` cadence unbroken.
4. **Bounce:** RUN from seed → after 7 `en` pulses `sr_q`=8'h80. The next tick gives no `en`, `dir`→1, `cnt`=7. The tick after gives `en` with `dir`=1 and `cnt`=8.
5. **Pause and step:** key0 press in RUN → `state`=3, no further `en`. key1 press → exactly one `en`, `cnt`+1. key0 press → first `en` 4 cycles after `state` returns to 2.
6. **Simultaneous keys and mid-run reset:**
   - key3+key0 pressed together in RUN → LOAD (key0 discarded), `cnt`=0, `dir`=0, `state` 2 after.
   - `rst` asserted mid-RUN → all outputs at reset values before the next clock edge.
